reg_file: RTL and testbench
===========================

# reg_file

Integer register file for the 32-bit RISC-V core. It receives write-back traffic from the WB stage (`op_write`, `write_addr`, `write_data`) and serves two combinational read ports to the ID stage. A write addressed to a register being read in the same cycle is bypassed to the read port. After reset, a clear sequencer zeroes all registers one per cycle before normal operation begins.

## Interface
Parameters:
- `XLEN`, 32: register and data width.
- `NUM_REGS`, 32: number of architectural registers (x0..x31).
- `AW`, 5: register index width, log2(`NUM_REGS`).

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op_write` in 1: write enable from the WB stage.
- `write_addr` in 32: destination register from the WB stage. Bits [AW-1:0] select the register; bits [31:AW] are ignored.
- `write_data` in XLEN: write-back value from the WB stage.
- `rs1_addr` in AW: read port 1 index from ID.
- `rs2_addr` in AW: read port 2 index from ID.
- `rs1_data` out XLEN: read port 1 data.
- `rs2_data` out XLEN: read port 2 data.
- `busy` out 1: high while the post-reset clear sequence is running. ID/hazard logic stalls on it.

## Operation
- FSM states:
  - `CLEAR`: entered on any cycle with `rst`=1. Counter `clr_idx` is set to 0.
    - Each cycle in `CLEAR` with `rst`=0 writes 0 to `regs[clr_idx]` and increments `clr_idx`.
    - After the write at `clr_idx`=NUM_REGS-1, the FSM goes to `RUN`.
  - `RUN`: normal operation; stays there until the next `rst`.
- Writes in `RUN`: on a rising edge with `op_write`=1 and `write_addr[AW-1:0]`≠0, `regs[write_addr[AW-1:0]]` ← `write_data`.
  - Writes to x0 are dropped.
  - Writes in `CLEAR` (including during the `rst` cycle) are dropped, not queued.
- Reads are combinational. For each port p:
  - If `busy`=1: `rsp_data`=0.
  - Else if `rsp_addr`=0: `rsp_data`=0.
  - Else if `op_write`=1 and `write_addr[AW-1:0]`=`rsp_addr`: `rsp_data`=`write_data` (bypass).
  - Else: `rsp_data`=`regs[rsp_addr]`.
- Both ports may read the same register. Both may hit the bypass simultaneously.
- The x0 check takes priority over the bypass: a write to x0 with `rs1_addr`=0 still reads 0.

## Timing
- Reset values:
  - The clock edge with `rst`=1 sets: `busy`=1, state `CLEAR`, `clr_idx`=0.
  - `rs1_data`/`rs2_data` read 0 throughout `CLEAR`.
  - Register contents are undefined until each is cleared.
- Clear duration: `rst` deasserts before edge E0. Edges E0..E31 clear x0..x31. `busy` is low after E31, i.e. 32 cycles after `rst` falls.
- `rst` asserted mid-clear or mid-`RUN`: the clear restarts from index 0 at the next edge. No partial state is retained.
- Write latency: data is visible on a read port in the same cycle through the bypass, and from the array after the next rising edge.
- Read latency: 0 cycles (combinational from `rsp_addr`, `busy`, `op_write`, `write_addr`, `write_data`).
- No handshake on writes: WB asserts `op_write` for exactly one cycle per retiring instruction. Back-to-back writes to the same register resolve as last-write-wins.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN`, `REG_AW`, `NUM_REGS` constants.
  - The `rf_state_t` enum (`CLEAR`, `RUN`).
  - A `ZERO_REG` index constant, reused by decode and hazard logic.
- One sub-module, `rf_clear_seq`, contains the FSM plus `clr_idx` counter. It outputs `clr_we`, `clr_idx` and `busy`. The top level muxes the clear write ahead of the WB write.
- The storage array and bypass muxes stay in `reg_file`.

## Test plan
- Reset then idle: hold `rst`=1 for 2 cycles, then release. `busy`=1 for exactly 32 cycles then 0. All 32 registers read 0 afterwards.
- Write/readback: write x5=0xDEADBEEF (`write_addr`=32'd5). Next cycle `rs1_addr`=5 gives `rs1_data`=0xDEADBEEF. `rs2_addr`=6 gives 0.
- Bypass and x0:
  - Same cycle `op_write`=1, `write_addr`=7, `write_data`=0x12345678, `rs1_addr`=`rs2_addr`=7: both ports read 0x12345678.
  - Write x0=0xFFFFFFFF: `rs1_addr`=0 reads 0 in that cycle and the next.
- Upper address bits ignored: `write_addr`=32'h0000_0023, `write_data`=0xA5. x3 reads 0xA5.
- Write during clear: `op_write`=1 to x9 at clear cycle 3 is dropped. x9 reads 0 after `busy` falls.
- Mid-run reset: write x10=0x55, then pulse `rst` for one cycle. `busy` is high for 32 cycles and x10 then reads 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants and types for the integer register file,
// decode and hazard logic.
package riscv_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/reg_file_if.sv
// Register file bus: WB-stage write port, two ID-stage read ports and the
// busy flag that stalls ID while the post-reset clear runs.
interface reg_file_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);

  logic            op_write;
  logic [31:0]     write_addr;
  logic [XLEN-1:0] write_data;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            busy;

  modport master (
    output op_write, write_addr, write_data, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, busy
  );

  modport slave (
    input  op_write, write_addr, write_data, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, busy
  );

endinterface

// File: rtl/rf_clear_seq.sv
// Post-reset clear sequencer: walks clr_idx over every register, one write
// per cycle, then parks in RUN until the next reset.
module rf_clear_seq #(
  parameter int NUM_REGS = riscv_pkg::NUM_REGS,
  parameter int AW       = riscv_pkg::REG_AW
) (
  input  logic          clk,
  input  logic          rst,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_idx_o,
  output logic          busy_o
);

  riscv_pkg::rf_state_t state_q, state_d;
  logic [AW-1:0]        idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= riscv_pkg::CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    clr_we_o = 1'b0;
    busy_o   = (state_q == riscv_pkg::CLEAR);
    case (state_q)
      riscv_pkg::CLEAR: begin
        // The reset cycle itself performs no clear write.
        clr_we_o = !rst;
        idx_d    = idx_q + 1'b1;
        if (idx_q == AW'(NUM_REGS - 1)) begin
          state_d = riscv_pkg::RUN;
        end
      end
      default: begin
        state_d = riscv_pkg::RUN;
      end
    endcase
  end

  assign clr_idx_o = idx_q;

endmodule

// File: rtl/reg_file.sv
// Integer register file: storage array, WB write port muxed behind the clear
// sequencer, and two combinational read ports with same-cycle write bypass.
module reg_file #(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int NUM_REGS = riscv_pkg::NUM_REGS,
  parameter int AW       = riscv_pkg::REG_AW
) (
  input  logic     clk,
  input  logic     rst,
  reg_file_if.slave rf
);

  logic [XLEN-1:0] regs_q [NUM_REGS];

  logic          clr_we;
  logic [AW-1:0] clr_idx;
  logic          busy;
  logic [AW-1:0] wb_idx;
  logic          wb_we;
  logic          unused_wa;

  rf_clear_seq #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_we_o  (clr_we),
    .clr_idx_o (clr_idx),
    .busy_o    (busy)
  );

  assign wb_idx    = rf.write_addr[AW-1:0];
  assign unused_wa = ^rf.write_addr[31:AW];
  // WB writes are discarded (not queued) while clearing or in reset.
  assign wb_we     = rf.op_write && !busy && !rst && (wb_idx != riscv_pkg::ZERO_REG);

  always_ff @(posedge clk) begin
    if (clr_we) begin
      regs_q[clr_idx] <= '0;
    end else if (wb_we) begin
      regs_q[wb_idx] <= rf.write_data;
    end
  end

  logic [AW-1:0]   rd_addr [2];
  logic [XLEN-1:0] rd_data [2];

  assign rd_addr[0] = rf.rs1_addr;
  assign rd_addr[1] = rf.rs2_addr;

  // x0 check outranks the bypass so a write to x0 never leaks onto a port.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    assign rd_data[gi] =
      (busy || (rd_addr[gi] == riscv_pkg::ZERO_REG)) ? '0 :
      (rf.op_write && (wb_idx == rd_addr[gi]))       ? rf.write_data :
                                                       regs_q[rd_addr[gi]];
  end

  assign rf.rs1_data = rd_data[0];
  assign rf.rs2_data = rd_data[1];
  assign rf.busy     = busy;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: clear sequence, write/readback, bypass, x0,
// address aliasing, dropped writes during clear and mid-run reset.
module tb_reg_file;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  reg_file_if #(.XLEN(32), .AW(5)) bus ();

  reg_file dut (
    .clk (clk),
    .rst (rst),
    .rf  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    bus.op_write   = 1'b0;
    bus.write_addr = '0;
    bus.write_data = '0;
    bus.rs1_addr   = '0;
    bus.rs2_addr   = '0;

    // Reset held for two cycles, then the 32-cycle clear.
    tick();
    tick();
    chk("reset_busy", {31'd0, bus.busy}, 32'd1);
    bus.rs1_addr = 5'd4;
    #1;
    chk("reset_rs1", bus.rs1_data, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 32; k++) begin
      #1;
      chk($sformatf("clear_busy_%0d", k), {31'd0, bus.busy}, 32'd1);
      tick();
    end
    chk("clear_done", {31'd0, bus.busy}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      bus.rs1_addr = 5'(i);
      bus.rs2_addr = 5'(31 - i);
      #1;
      chk($sformatf("zero_rs1_x%0d", i), bus.rs1_data, 32'd0);
      chk($sformatf("zero_rs2_x%0d", 31 - i), bus.rs2_data, 32'd0);
    end

    // Write then read back through the array.
    bus.op_write = 1'b1; bus.write_addr = 32'd5; bus.write_data = 32'hDEADBEEF;
    tick();
    bus.op_write = 1'b0; bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd6;
    #1;
    chk("wr_x5_rs1", bus.rs1_data, 32'hDEADBEEF);
    chk("wr_x6_rs2", bus.rs2_data, 32'd0);

    // Same-cycle bypass on both ports.
    bus.op_write = 1'b1; bus.write_addr = 32'd7; bus.write_data = 32'h12345678;
    bus.rs1_addr = 5'd7; bus.rs2_addr = 5'd7;
    #1;
    chk("byp_rs1", bus.rs1_data, 32'h12345678);
    chk("byp_rs2", bus.rs2_data, 32'h12345678);
    tick();
    bus.op_write = 1'b0;
    #1;
    chk("byp_array_rs1", bus.rs1_data, 32'h12345678);

    // Write to x0 never becomes visible.
    bus.op_write = 1'b1; bus.write_addr = 32'd0; bus.write_data = 32'hFFFFFFFF;
    bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd5;
    #1;
    chk("x0_same_cycle", bus.rs1_data, 32'd0);
    chk("x0_other_port", bus.rs2_data, 32'hDEADBEEF);
    tick();
    bus.op_write = 1'b0;
    #1;
    chk("x0_next_cycle", bus.rs1_data, 32'd0);

    // Upper write address bits ignored: 0x23 aliases x3.
    bus.op_write = 1'b1; bus.write_addr = 32'h0000_0023; bus.write_data = 32'h000000A5;
    bus.rs2_addr = 5'd3;
    #1;
    chk("alias_bypass_x3", bus.rs2_data, 32'h000000A5);
    tick();
    bus.op_write = 1'b0; bus.rs1_addr = 5'd3;
    #1;
    chk("alias_array_x3", bus.rs1_data, 32'h000000A5);

    // Back-to-back writes, last one wins.
    bus.op_write = 1'b1; bus.write_addr = 32'd12; bus.write_data = 32'h11111111;
    tick();
    bus.write_data = 32'h22222222;
    tick();
    bus.op_write = 1'b0; bus.rs1_addr = 5'd12;
    #1;
    chk("lww_x12", bus.rs1_data, 32'h22222222);

    // Mid-run reset wipes x10; writes issued during the clear are dropped.
    bus.op_write = 1'b1; bus.write_addr = 32'd10; bus.write_data = 32'h00000055;
    tick();
    bus.op_write = 1'b0; bus.rs1_addr = 5'd10;
    #1;
    chk("x10_before_rst", bus.rs1_data, 32'h00000055);
    rst = 1'b1;
    bus.op_write = 1'b1; bus.write_addr = 32'd11; bus.write_data = 32'h0000BEEF;
    tick();
    bus.op_write = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd1);
    chk("midrst_rs1", bus.rs1_data, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 32; k++) begin
      bus.op_write   = (k == 3) || (k == 20);
      bus.write_addr = 32'd9;
      bus.write_data = 32'h00000099;
      bus.rs2_addr   = 5'd9;
      #1;
      chk($sformatf("reclear_busy_%0d", k), {31'd0, bus.busy}, 32'd1);
      if (k == 3 || k == 20) chk($sformatf("reclear_byp_%0d", k), bus.rs2_data, 32'd0);
      tick();
    end
    bus.op_write = 1'b0;
    #1;
    chk("reclear_done", {31'd0, bus.busy}, 32'd0);
    bus.rs1_addr = 5'd10; bus.rs2_addr = 5'd9;
    #1;
    chk("x10_after_rst", bus.rs1_data, 32'd0);
    chk("x9_dropped", bus.rs2_data, 32'd0);
    bus.rs1_addr = 5'd11; bus.rs2_addr = 5'd5;
    #1;
    chk("x11_rst_cycle_dropped", bus.rs1_data, 32'd0);
    chk("x5_after_rst", bus.rs2_data, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
